// File: rtl/experiment_shot_scheduler.sv
// -----------------------------------------------------------------------------
// experiment_shot_scheduler
//
// Campaign-level controller that fires a programmed number of experiment shots.
// For each shot it waits for the detector to report ready, then waits for the
// fast-gate window to close, then drives a fixed-length start pulse into the
// experiment FSM. After that it waits for the experiment's output trigger and
// holds off for a cooldown period before the next shot. If a shot never
// completes, the controller parks in FAULT until the operator drops the run
// request.
//
// Parameters
//   SHOT_W           width of the shot total and the shot counter
//   TIMER_W          width of the shared per-state cycle timer
//   START_CYCLES     start pulse length in clocks
//   COOLDOWN_CYCLES  minimum idle clocks between shots
//   TIMEOUT_CYCLES   maximum clocks in WAIT_SHOT before declaring a fault
//
// Ports
//   clock           in   system clock
//   reset_signal    in   asynchronous active-low reset
//   run_request     in   level; a rising edge starts a campaign
//   abort           in   ends any campaign in progress
//   shot_total      in   shots per campaign, latched at campaign start
//   fg_signal       in   fast-gate opto (asynchronous, 2-flop synchronised)
//   detector_ready  in   detector ready (asynchronous, 2-flop synchronised)
//   output_trigger  in   experiment FSM shot-complete (same clock domain)
//   start_signal    out  start pulse to the experiment FSM
//   busy            out  high in every state except IDLE
//   done_pulse      out  one-cycle pulse when a campaign completes
//   timeout_flag    out  set when a shot timed out; cleared at next campaign
//   shots_done      out  completed shots in the current or last campaign
//   sched_state     out  current state encoding, for debug
// -----------------------------------------------------------------------------
module experiment_shot_scheduler #(
   parameter int SHOT_W          = 8,
   parameter int TIMER_W         = 24,
   parameter int START_CYCLES    = 20000,
   parameter int COOLDOWN_CYCLES = 1300000,
   parameter int TIMEOUT_CYCLES  = 4000000
) (
   input  logic              clock,
   input  logic              reset_signal,
   input  logic              run_request,
   input  logic              abort,
   input  logic [SHOT_W-1:0] shot_total,
   input  logic              fg_signal,
   input  logic              detector_ready,
   input  logic              output_trigger,
   output logic              start_signal,
   output logic              busy,
   output logic              done_pulse,
   output logic              timeout_flag,
   output logic [SHOT_W-1:0] shots_done,
   output logic [2:0]        sched_state
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_READY = 3'd1,
      S_WAIT_GATE  = 3'd2,
      S_START      = 3'd3,
      S_WAIT_SHOT  = 3'd4,
      S_COOLDOWN   = 3'd5,
      S_DONE       = 3'd6,
      S_FAULT      = 3'd7
   } state_t;

   // Terminal timer values: the timer reads 0 on the first cycle in a state,
   // so reaching N-1 means the state has been occupied for exactly N cycles.
   localparam logic [TIMER_W-1:0] START_LAST    = TIMER_W'(START_CYCLES - 1);
   localparam logic [TIMER_W-1:0] COOLDOWN_LAST = TIMER_W'(COOLDOWN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);

   state_t              r_state;
   state_t              w_next_state;

   logic                r_fg_meta;
   logic                r_fg_sync;
   logic                r_fg_prev;
   logic                r_rdy_meta;
   logic                r_rdy_sync;
   logic                r_run_prev;
   logic                r_trig_prev;
   logic                r_trig_rise;

   logic [TIMER_W-1:0]  r_timer;
   logic [SHOT_W-1:0]   r_shot_total;
   logic [SHOT_W-1:0]   r_shots_done;
   logic                r_start;
   logic                r_busy;
   logic                r_done;
   logic                r_timeout;

   logic                w_fg_fall;
   logic                w_run_rise;
   logic [SHOT_W-1:0]   w_shots_inc;
   logic                w_campaign_start;
   logic                w_shot_count;

   // --------------------------------------------------------------------------
   // Input conditioning
   // --------------------------------------------------------------------------
   // The gate and ready inputs come from outside the clock domain and get two
   // flops each. The falling edge of the gate is taken combinationally from the
   // synchronised value and its one-cycle-old copy, so the state register sees
   // it on the third clock after the raw fall.
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_fg_meta  <= 1'b0;
         r_fg_sync  <= 1'b0;
         r_fg_prev  <= 1'b0;
         r_rdy_meta <= 1'b0;
         r_rdy_sync <= 1'b0;
      end else begin
         // NOTE: every clocked register uses non-blocking assignment so that all
         // flops sample their inputs from the same pre-edge values; a blocking
         // '=' here would collapse the two synchroniser stages into one.
         r_fg_meta  <= fg_signal;
         r_fg_sync  <= r_fg_meta;
         r_fg_prev  <= r_fg_sync;
         r_rdy_meta <= detector_ready;
         r_rdy_sync <= r_rdy_meta;
      end
   end

   assign w_fg_fall = r_fg_prev & ~r_fg_sync;

   // run_request and output_trigger are already in this clock domain. The
   // trigger edge is registered, so the shot counter moves two clocks after the
   // raw trigger rise; a trigger edge that lands outside WAIT_SHOT is dropped.
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_run_prev  <= 1'b0;
         r_trig_prev <= 1'b0;
         r_trig_rise <= 1'b0;
      end else begin
         r_run_prev  <= run_request;
         r_trig_prev <= output_trigger;
         r_trig_rise <= output_trigger & ~r_trig_prev;
      end
   end

   assign w_run_rise  = run_request & ~r_run_prev;
   assign w_shots_inc = r_shots_done + SHOT_W'(1);

   // --------------------------------------------------------------------------
   // State machine
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default before any branch, so
      // no path leaves it unassigned and no latch is inferred.
      w_next_state     = r_state;
      w_campaign_start = 1'b0;
      w_shot_count     = 1'b0;

      if ((r_state != S_IDLE) && abort) begin
         // Abort beats every other transition, including a trigger edge.
         w_next_state = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               // A zero shot total would never reach DONE; refuse it.
               if (w_run_rise && (shot_total != '0)) begin
                  w_next_state     = S_WAIT_READY;
                  w_campaign_start = 1'b1;
               end
            end
            S_WAIT_READY: begin
               if (r_rdy_sync) begin
                  w_next_state = S_WAIT_GATE;
               end
            end
            S_WAIT_GATE: begin
               // Fire just after the gate window closes.
               if (w_fg_fall) begin
                  w_next_state = S_START;
               end
            end
            S_START: begin
               if (r_timer == START_LAST) begin
                  w_next_state = S_WAIT_SHOT;
               end
            end
            S_WAIT_SHOT: begin
               // The trigger is tested first so a trigger on the final
               // timeout cycle still counts as a completed shot.
               if (r_trig_rise) begin
                  w_shot_count = 1'b1;
                  if (w_shots_inc == r_shot_total) begin
                     w_next_state = S_DONE;
                  end else begin
                     w_next_state = S_COOLDOWN;
                  end
               end else if (r_timer == TIMEOUT_LAST) begin
                  w_next_state = S_FAULT;
               end
            end
            S_COOLDOWN: begin
               if (r_timer == COOLDOWN_LAST) begin
                  w_next_state = S_WAIT_READY;
               end
            end
            S_DONE: begin
               w_next_state = S_IDLE;
            end
            S_FAULT: begin
               // Hold the fault until the operator withdraws the request.
               if (!run_request) begin
                  w_next_state = S_IDLE;
               end
            end
            default: begin
               w_next_state = S_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Shared timer: zero on the first cycle of every state, then counts up and
   // sticks at all-ones rather than wrapping back into a terminal value.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_timer <= '0;
      end else if (w_next_state != r_state) begin
         r_timer <= '0;
      end else if (!(&r_timer)) begin
         r_timer <= r_timer + TIMER_W'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Campaign bookkeeping and registered outputs
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_shot_total <= '0;
         r_shots_done <= '0;
         r_timeout    <= 1'b0;
      end else begin
         if (w_campaign_start) begin
            r_shot_total <= shot_total;
            r_shots_done <= '0;
            r_timeout    <= 1'b0;
         end else begin
            // The counter can only wrap if the total exceeds 2^SHOT_W-1,
            // which the port width rules out.
            if (w_shot_count) begin
               r_shots_done <= w_shots_inc;
            end
            // Sticky through FAULT and the return to IDLE.
            if (w_next_state == S_FAULT) begin
               r_timeout <= 1'b1;
            end
         end
      end
   end

   // The start pulse trails the START state by one clock, so it stays high for
   // exactly START_CYCLES clocks. An abort clears it on the same edge that
   // sends the state back to IDLE.
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_start <= (r_state == S_START) && !abort;
         r_busy  <= (w_next_state != S_IDLE);
         r_done  <= (w_next_state == S_DONE);
      end
   end

   assign start_signal = r_start;
   assign busy         = r_busy;
   assign done_pulse   = r_done;
   assign timeout_flag = r_timeout;
   assign shots_done   = r_shots_done;
   assign sched_state  = r_state;

   // --------------------------------------------------------------------------
   // Structural invariants
   // --------------------------------------------------------------------------
   a_busy_tracks_state : assert property (
      @(posedge clock) disable iff (!reset_signal)
      busy == (r_state != S_IDLE));

   a_done_single_cycle : assert property (
      @(posedge clock) disable iff (!reset_signal)
      done_pulse |=> !done_pulse);

   a_start_implies_busy : assert property (
      @(posedge clock) disable iff (!reset_signal)
      start_signal |-> busy);

endmodule

// File: doc/experiment_shot_scheduler.md
# experiment_shot_scheduler

Campaign-level controller that sequences repeated shots of the experiment FSM. On a run request it waits for the detector to be ready, aligns to the fast-gate window and issues a timed start pulse. It then waits for the experiment's output trigger, enforces a cooldown and repeats until the programmed shot count is reached. It sits between the operator/host control registers and the experiment FSM's `start_signal` input, and flags a fault when a shot never completes.

## Interface
- `SHOT_W`, 8: width of shot count and shot counter.
- `TIMER_W`, 24: width of the shared cycle timer.
- `START_CYCLES`, 20000: start pulse length in clocks (100 us at 200 MHz).
- `COOLDOWN_CYCLES`, 1300000: minimum idle clocks between shots (6.5 ms).
- `TIMEOUT_CYCLES`, 4000000: maximum clocks from start pulse end to output trigger (20 ms).
- `clock`  in  1  system clock, 200 MHz.
- `reset_signal`  in  1  reset; asynchronous, active-low.
- `run_request`  in  1  synchronous level; a rising edge starts a campaign.
- `abort`  in  1  synchronous; when high, ends any campaign.
- `shot_total`  in  SHOT_W  shots per campaign; latched at campaign start.
- `fg_signal`  in  1  fast-gate opto, asynchronous; synchronised internally with 2 flip-flops.
- `detector_ready`  in  1  asynchronous; synchronised internally with 2 flip-flops.
- `output_trigger`  in  1  from the experiment FSM, same clock domain; a rising edge means the shot is complete.
- `start_signal`  out  1  start pulse to the experiment FSM.
- `busy`  out  1  high in every state except IDLE.
- `done_pulse`  out  1  one-cycle pulse when a campaign completes.
- `timeout_flag`  out  1  set in FAULT.
- `shots_done`  out  SHOT_W  count of completed shots in the current or last campaign.
- `sched_state`  out  3  state encoding, for debug.

## Operation
- State encodings: IDLE=0, WAIT_READY=1, WAIT_GATE=2, START=3, WAIT_SHOT=4, COOLDOWN=5, DONE=6, FAULT=7.
- One timer, TIMER_W bits wide, clears on every state entry and increments each cycle. It saturates and never wraps.
- IDLE: on a `run_request` rising edge with `shot_total`≠0, latch `shot_total`, clear `shots_done` and `timeout_flag`, and go to WAIT_READY. If `shot_total`=0, ignore the edge and stay in IDLE.
- WAIT_READY: when synchronised `detector_ready`=1, go to WAIT_GATE.
- WAIT_GATE: on a falling edge of synchronised `fg_signal` (gate window just ended), go to START.
- START: `start_signal`=1. When timer reaches START_CYCLES−1, go to WAIT_SHOT, so the pulse lasts exactly START_CYCLES clocks.
- WAIT_SHOT, on an `output_trigger` rising edge:
  - Increment `shots_done`.
  - If the new value equals the latched total, go to DONE; otherwise go to COOLDOWN.
- WAIT_SHOT, on timeout: if timer reaches TIMEOUT_CYCLES−1 with no edge, go to FAULT.
- If the trigger edge and the timeout occur in the same cycle, the trigger edge wins.
- COOLDOWN: when timer reaches COOLDOWN_CYCLES−1, go to WAIT_READY.
- DONE: `done_pulse`=1 for one cycle, then go to IDLE.
- FAULT: `timeout_flag`=1 and `busy`=1. Stay until `run_request`=0, then go to IDLE. `timeout_flag` stays set until the next campaign starts.
- `abort`=1 in any state other than IDLE:
  - Go to IDLE next cycle and drop `start_signal` that cycle.
  - Keep `shots_done`; do not pulse `done_pulse`.
  - Abort has priority over all other transitions.
- A `run_request` edge while `busy` is ignored.
- The `shots_done` increment wraps modulo 2^SHOT_W; it is unreachable because the total is ≤ 2^SHOT_W−1.

## Timing
- Reset values: state=IDLE, and `start_signal`, `busy`, `done_pulse`, `timeout_flag`, `shots_done`, timer all 0. Synchroniser flops reset to 0.
- All outputs are registered.
- `start_signal` rises 1 cycle after entering START.
- Latency from a raw `fg_signal` fall to `start_signal` rise is 4 clocks: 2 sync, 1 edge detect, 1 state register.
- Latency from a raw `detector_ready` rise to leaving WAIT_READY is 3 clocks.
- `output_trigger` is edge-detected with one register; `shots_done` updates 2 clocks after the raw rise.
- An `output_trigger` edge seen outside WAIT_SHOT is ignored.
- `reset_signal` asserted mid-campaign forces the reset values immediately (asynchronous). The first transition is possible one cycle after deassertion.

## Test plan
Parameters for all tests: START_CYCLES=4, COOLDOWN_CYCLES=10, TIMEOUT_CYCLES=50.

- Nominal: `shot_total`=3, `detector_ready`=1, `fg_signal` toggling every 20 clocks, `output_trigger` rising 6 clocks after each start pulse → 3 start pulses of exactly 4 clocks each, each ≥10 clocks after the previous trigger; `shots_done`=3; one `done_pulse`; `busy` back to 0.
- Detector gating: hold `detector_ready`=0 for 100 clocks after the campaign start → no `start_signal` until 3 clocks after the ready rise plus the next gate fall.
- Timeout: never assert `output_trigger` → after 50 clocks in WAIT_SHOT, state=7 and `timeout_flag`=1. Drop `run_request` → IDLE. A new run clears `timeout_flag`.
- Simultaneous: `output_trigger` edge on the last timeout cycle → counted, no FAULT.
- Abort during START cycle 2 with `shot_total`=5, `shots_done`=1 → `start_signal` low next cycle, IDLE, `shots_done`=1, no `done_pulse`.
- Reset mid-campaign: assert `reset_signal`=0 during COOLDOWN → all outputs 0 asynchronously. A `shot_total`=0 request afterwards is ignored and `busy` stays 0.
